// File: rtl/asic_mem_port_if.sv
`default_nettype none
// ============================================================================
// Module      : asic_mem_port_if
// Description : Request, memory and writeback bundle for asic_mem_port.
// Revision    : 1.0 - initial release
// ============================================================================
interface asic_mem_port_if #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64,
    parameter int TAG_BITS  = 2,
    parameter int R_ADDR    = 4
);
    logic                 req_val_i;
    logic                 req_rdy_o;
    logic                 req_store_i;
    logic [ADDR_BITS-1:0] req_addr_i;
    logic [DATA_BITS-1:0] req_data_i;
    logic [R_ADDR-1:0]    req_rd_i;

    logic                 mem_req_val_o;
    logic                 mem_req_rdy_i;
    logic                 mem_req_store_o;
    logic [ADDR_BITS-1:0] mem_req_addr_o;
    logic [DATA_BITS-1:0] mem_req_data_o;
    logic [TAG_BITS-1:0]  mem_req_tag_o;

    logic                 mem_resp_val_i;
    logic [TAG_BITS-1:0]  mem_resp_tag_i;
    logic [DATA_BITS-1:0] mem_resp_data_i;

    logic                 wb_val_o;
    logic                 wb_rdy_i;
    logic [DATA_BITS-1:0] wb_data_o;
    logic [R_ADDR-1:0]    wb_raddr_o;

    logic                 busy_o;
    logic                 err_o;

    // The memory port itself.
    modport slave (
        input  req_val_i, req_store_i, req_addr_i, req_data_i, req_rd_i,
        output req_rdy_o,
        output mem_req_val_o, mem_req_store_o, mem_req_addr_o, mem_req_data_o, mem_req_tag_o,
        input  mem_req_rdy_i,
        input  mem_resp_val_i, mem_resp_tag_i, mem_resp_data_i,
        output wb_val_o, wb_data_o, wb_raddr_o,
        input  wb_rdy_i,
        output busy_o, err_o
    );

    // Datapath control plus processor memory system surrounding the port.
    modport master (
        output req_val_i, req_store_i, req_addr_i, req_data_i, req_rd_i,
        input  req_rdy_o,
        input  mem_req_val_o, mem_req_store_o, mem_req_addr_o, mem_req_data_o, mem_req_tag_o,
        output mem_req_rdy_i,
        output mem_resp_val_i, mem_resp_tag_i, mem_resp_data_i,
        input  wb_val_o, wb_data_o, wb_raddr_o,
        output wb_rdy_i,
        input  busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/asic_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : asic_mem_port
// Description : Tagged memory request issue stage with load writeback FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module asic_mem_port #(
    parameter int ADDR_BITS = 40,
    parameter int DATA_BITS = 64,
    parameter int TAG_BITS  = 2,
    parameter int R_ADDR    = 4,
    parameter int WB_DEPTH  = 2
) (
    input  logic            clk,
    input  logic            reset,
    asic_mem_port_if.slave  bus
);
    localparam int c_NTAGS = 1 << TAG_BITS;
    localparam int c_PTR_W = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int c_CNT_W = $clog2(WB_DEPTH + 1);

    logic                 r_iss_val;
    logic                 r_iss_store;
    logic [ADDR_BITS-1:0] r_iss_addr;
    logic [DATA_BITS-1:0] r_iss_data;
    logic [TAG_BITS-1:0]  r_iss_tag;

    logic [c_NTAGS-1:0]   r_tag_alloc;
    logic [c_NTAGS-1:0]   r_tag_store;
    logic [R_ADDR-1:0]    r_tag_rd [c_NTAGS];

    logic [DATA_BITS-1:0] r_fifo_data [WB_DEPTH];
    logic [R_ADDR-1:0]    r_fifo_rd   [WB_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 r_err;

    logic                 w_free_found;
    logic [TAG_BITS-1:0]  w_free_tag;
    logic [31:0]          w_load_pend;
    logic                 w_credit_ok;
    logic                 w_mem_fire;
    logic                 w_req_rdy;
    logic                 w_accept;
    logic                 w_resp_hit;
    logic                 w_resp_miss;
    logic                 w_push;
    logic                 w_pop;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Lowest free tag wins: scan high-to-low so the last hit is the lowest index.
    always_comb begin
        w_free_found = 1'b0;
        w_free_tag   = '0;
        for (int i = c_NTAGS - 1; i >= 0; i--) begin
            if (!r_tag_alloc[i]) begin
                w_free_found = 1'b1;
                w_free_tag   = TAG_BITS'(i);
            end
        end
    end

    // Every in-flight load reserves a FIFO slot so responses never need backpressure.
    always_comb begin
        w_load_pend = 32'(r_count);
        for (int i = 0; i < c_NTAGS; i++) begin
            if (r_tag_alloc[i] && !r_tag_store[i]) begin
                w_load_pend = w_load_pend + 32'd1;
            end
        end
    end

    assign w_credit_ok = (w_load_pend < 32'(WB_DEPTH));
    assign w_mem_fire  = r_iss_val & bus.mem_req_rdy_i;
    assign w_req_rdy   = reset & (~r_iss_val | w_mem_fire) & w_free_found
                         & (bus.req_store_i | w_credit_ok);
    assign w_accept    = bus.req_val_i & w_req_rdy;
    assign w_resp_hit  = bus.mem_resp_val_i &  r_tag_alloc[bus.mem_resp_tag_i];
    assign w_resp_miss = bus.mem_resp_val_i & ~r_tag_alloc[bus.mem_resp_tag_i];
    assign w_push      = w_resp_hit & ~r_tag_store[bus.mem_resp_tag_i];
    assign w_pop       = (r_count != '0) & bus.wb_rdy_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_iss_val   <= 1'b0;
            r_iss_store <= 1'b0;
            r_iss_addr  <= '0;
            r_iss_data  <= '0;
            r_iss_tag   <= '0;
            r_tag_alloc <= '0;
            r_tag_store <= '0;
            for (int i = 0; i < c_NTAGS; i++) begin
                r_tag_rd[i] <= '0;
            end
            for (int i = 0; i < WB_DEPTH; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_rd[i]   <= '0;
            end
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iss_val               <= 1'b1;
                r_iss_store             <= bus.req_store_i;
                r_iss_addr              <= bus.req_addr_i;
                r_iss_data              <= bus.req_data_i;
                r_iss_tag               <= w_free_tag;
                r_tag_alloc[w_free_tag] <= 1'b1;
                r_tag_store[w_free_tag] <= bus.req_store_i;
                r_tag_rd[w_free_tag]    <= bus.req_rd_i;
            end else if (w_mem_fire) begin
                r_iss_val <= 1'b0;
            end

            // Allocation only targets free tags, so this never collides with the set above.
            if (w_resp_hit) begin
                r_tag_alloc[bus.mem_resp_tag_i] <= 1'b0;
            end
            if (w_resp_miss) begin
                r_err <= 1'b1;
            end

            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= bus.mem_resp_data_i;
                r_fifo_rd[r_wr_ptr]   <= r_tag_rd[bus.mem_resp_tag_i];
                r_wr_ptr              <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.req_rdy_o       = w_req_rdy;
    assign bus.mem_req_val_o   = r_iss_val;
    assign bus.mem_req_store_o = r_iss_store;
    assign bus.mem_req_addr_o  = r_iss_addr;
    assign bus.mem_req_data_o  = r_iss_data;
    assign bus.mem_req_tag_o   = r_iss_tag;
    assign bus.wb_val_o        = (r_count != '0);
    assign bus.wb_data_o       = r_fifo_data[r_rd_ptr];
    assign bus.wb_raddr_o      = r_fifo_rd[r_rd_ptr];
    assign bus.busy_o          = r_iss_val | (|r_tag_alloc) | (r_count != '0);
    assign bus.err_o           = r_err;
endmodule
`default_nettype wire

// File: tb/tb_asic_mem_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_asic_mem_port
// Description : Directed scoreboard bench for asic_mem_port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asic_mem_port;
    localparam int c_AB = 40;
    localparam int c_DB = 64;
    localparam int c_TB = 2;
    localparam int c_RA = 4;

    typedef struct packed {
        logic            store;
        logic [c_AB-1:0] addr;
        logic [c_DB-1:0] data;
        logic [c_TB-1:0] tag;
    } mreq_t;

    typedef struct packed {
        logic [c_DB-1:0] data;
        logic [c_RA-1:0] rd;
    } wb_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    mreq_t exp_mreq[$];
    wb_t   exp_wb[$];

    asic_mem_port_if #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .TAG_BITS(c_TB), .R_ADDR(c_RA)) bus ();

    asic_mem_port #(.ADDR_BITS(c_AB), .DATA_BITS(c_DB), .TAG_BITS(c_TB), .R_ADDR(c_RA), .WB_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic st, input logic [c_AB-1:0] a, input logic [c_DB-1:0] d,
                             input logic [c_RA-1:0] rd);
        bus.req_val_i   = 1'b1;
        bus.req_store_i = st;
        bus.req_addr_i  = a;
        bus.req_data_i  = d;
        bus.req_rd_i    = rd;
    endtask

    task automatic idle_req();
        bus.req_val_i   = 1'b0;
        bus.req_store_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_data_i  = '0;
        bus.req_rd_i    = '0;
    endtask

    task automatic drive_resp(input logic v, input logic [c_TB-1:0] t, input logic [c_DB-1:0] d);
        bus.mem_resp_val_i  = v;
        bus.mem_resp_tag_i  = t;
        bus.mem_resp_data_i = d;
    endtask

    task automatic push_mreq(input logic st, input logic [c_AB-1:0] a, input logic [c_DB-1:0] d,
                             input logic [c_TB-1:0] t);
        mreq_t m;
        m.store = st; m.addr = a; m.data = d; m.tag = t;
        exp_mreq.push_back(m);
    endtask

    task automatic push_wb(input logic [c_DB-1:0] d, input logic [c_RA-1:0] rd);
        wb_t w;
        w.data = d; w.rd = rd;
        exp_wb.push_back(w);
    endtask

    // Handshake scoreboards, sampled mid-cycle where inputs and outputs are stable.
    always @(negedge clk) begin
        if (reset && bus.mem_req_val_o && bus.mem_req_rdy_i) begin
            check("mreq_expected", 128'(exp_mreq.size() != 0), 128'(1));
            if (exp_mreq.size() != 0) begin
                mreq_t obs, e;
                obs = {bus.mem_req_store_o, bus.mem_req_addr_o, bus.mem_req_data_o, bus.mem_req_tag_o};
                e   = exp_mreq.pop_front();
                check("mreq", 128'(obs), 128'(e));
            end
        end
        if (reset && bus.wb_val_o && bus.wb_rdy_i) begin
            check("wb_expected", 128'(exp_wb.size() != 0), 128'(1));
            if (exp_wb.size() != 0) begin
                wb_t obs, e;
                obs = {bus.wb_data_o, bus.wb_raddr_o};
                e   = exp_wb.pop_front();
                check("wb", 128'(obs), 128'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_req();
        drive_resp(1'b0, '0, '0);
        bus.mem_req_rdy_i = 1'b0;
        bus.wb_rdy_i      = 1'b0;

        // Reset state
        tick();
        drive_req(1'b1, 40'h123, 64'h55, 4'd1);
        tick();
        check("rst_req_rdy",  128'(bus.req_rdy_o), 128'(0));
        check("rst_mreq_val", 128'(bus.mem_req_val_o), 128'(0));
        check("rst_wb_val",   128'(bus.wb_val_o), 128'(0));
        check("rst_busy",     128'(bus.busy_o), 128'(0));
        check("rst_err",      128'(bus.err_o), 128'(0));
        check("rst_addr",     128'(bus.mem_req_addr_o), 128'(0));
        check("rst_wb_data",  128'(bus.wb_data_o), 128'(0));
        idle_req();
        reset = 1'b1;
        bus.mem_req_rdy_i = 1'b1;
        bus.wb_rdy_i      = 1'b1;
        tick();

        // Single load
        drive_req(1'b0, 40'h100, 64'h0, 4'd5);
        push_mreq(1'b0, 40'h100, 64'h0, 2'd0);
        #1 check("load_rdy", 128'(bus.req_rdy_o), 128'(1));
        tick();
        idle_req();
        check("load_mreq_val", 128'(bus.mem_req_val_o), 128'(1));
        check("load_tag", 128'(bus.mem_req_tag_o), 128'(0));
        tick();
        drive_resp(1'b1, 2'd0, 64'hDEAD_BEEF);
        push_wb(64'hDEAD_BEEF, 4'd5);
        tick();
        drive_resp(1'b0, '0, '0);
        check("load_wb_val", 128'(bus.wb_val_o), 128'(1));
        check("load_wb_raddr", 128'(bus.wb_raddr_o), 128'(5));
        tick();
        check("load_busy_done", 128'(bus.busy_o), 128'(0));

        // Store
        drive_req(1'b1, 40'h40, 64'h1234, 4'd0);
        push_mreq(1'b1, 40'h40, 64'h1234, 2'd0);
        tick();
        idle_req();
        check("store_data", 128'(bus.mem_req_data_o), 128'(64'h1234));
        tick();
        drive_resp(1'b1, 2'd0, 64'h0);
        tick();
        drive_resp(1'b0, '0, '0);
        check("store_no_wb", 128'(bus.wb_val_o), 128'(0));
        check("store_busy", 128'(bus.busy_o), 128'(0));

        // Credit stall with writeback blocked
        bus.wb_rdy_i = 1'b0;
        drive_req(1'b0, 40'h200, 64'h0, 4'd1);
        push_mreq(1'b0, 40'h200, 64'h0, 2'd0);
        #1 check("cs_rdy1", 128'(bus.req_rdy_o), 128'(1));
        tick();
        drive_req(1'b0, 40'h208, 64'h0, 4'd2);
        push_mreq(1'b0, 40'h208, 64'h0, 2'd1);
        #1 check("cs_rdy2", 128'(bus.req_rdy_o), 128'(1));
        tick();
        drive_req(1'b0, 40'h210, 64'h0, 4'd3);
        #1 check("cs_stall", 128'(bus.req_rdy_o), 128'(0));
        tick();
        drive_resp(1'b1, 2'd0, 64'h11);
        push_wb(64'h11, 4'd1);
        tick();
        drive_resp(1'b1, 2'd1, 64'h22);
        push_wb(64'h22, 4'd2);
        tick();
        drive_resp(1'b0, '0, '0);
        #1 check("cs_full_stall", 128'(bus.req_rdy_o), 128'(0));
        check("cs_head", 128'(bus.wb_data_o), 128'(64'h11));
        bus.wb_rdy_i = 1'b1;
        tick();
        bus.wb_rdy_i = 1'b0;
        #1 check("cs_rdy_after_pop", 128'(bus.req_rdy_o), 128'(1));
        push_mreq(1'b0, 40'h210, 64'h0, 2'd0);
        tick();
        idle_req();
        tick();
        drive_resp(1'b1, 2'd0, 64'h33);
        push_wb(64'h33, 4'd3);
        tick();
        drive_resp(1'b0, '0, '0);
        bus.wb_rdy_i = 1'b1;
        tick(); tick(); tick();
        check("cs_drained", 128'(bus.busy_o), 128'(0));

        // Out-of-order responses
        drive_req(1'b0, 40'h300, 64'h0, 4'd3);
        push_mreq(1'b0, 40'h300, 64'h0, 2'd0);
        tick();
        drive_req(1'b0, 40'h308, 64'h0, 4'd7);
        push_mreq(1'b0, 40'h308, 64'h0, 2'd1);
        tick();
        idle_req();
        tick();
        drive_resp(1'b1, 2'd1, 64'hB);
        push_wb(64'hB, 4'd7);
        tick();
        drive_resp(1'b1, 2'd0, 64'hA);
        push_wb(64'hA, 4'd3);
        check("ooo_first_rd", 128'(bus.wb_raddr_o), 128'(7));
        tick();
        drive_resp(1'b0, '0, '0);
        tick(); tick();
        check("ooo_busy", 128'(bus.busy_o), 128'(0));

        // Memory backpressure
        bus.mem_req_rdy_i = 1'b0;
        drive_req(1'b0, 40'h400, 64'h0, 4'd4);
        push_mreq(1'b0, 40'h400, 64'h0, 2'd0);
        tick();
        drive_req(1'b0, 40'h408, 64'h0, 4'd6);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_val",  128'(bus.mem_req_val_o), 128'(1));
            check("bp_addr", 128'(bus.mem_req_addr_o), 128'(40'h400));
            check("bp_rdy",  128'(bus.req_rdy_o), 128'(0));
            tick();
        end
        bus.mem_req_rdy_i = 1'b1;
        push_mreq(1'b0, 40'h408, 64'h0, 2'd1);
        #1 check("bp_same_cycle_rdy", 128'(bus.req_rdy_o), 128'(1));
        tick();
        idle_req();
        check("bp_next_tag", 128'(bus.mem_req_tag_o), 128'(1));
        tick();
        drive_resp(1'b1, 2'd0, 64'h44);
        push_wb(64'h44, 4'd4);
        tick();
        drive_resp(1'b1, 2'd1, 64'h66);
        push_wb(64'h66, 4'd6);
        tick();
        drive_resp(1'b0, '0, '0);
        tick(); tick();
        check("bp_busy", 128'(bus.busy_o), 128'(0));

        // Unallocated-tag response
        drive_resp(1'b1, 2'd2, 64'h99);
        #1 check("err_before", 128'(bus.err_o), 128'(0));
        tick();
        drive_resp(1'b0, '0, '0);
        check("err_set", 128'(bus.err_o), 128'(1));
        tick();
        check("err_sticky", 128'(bus.err_o), 128'(1));
        check("err_no_wb", 128'(bus.wb_val_o), 128'(0));

        // Reset mid-transaction
        drive_req(1'b0, 40'h500, 64'h0, 4'd9);
        push_mreq(1'b0, 40'h500, 64'h0, 2'd0);
        tick();
        idle_req();
        tick();
        check("mid_busy", 128'(bus.busy_o), 128'(1));
        reset = 1'b0;
        drive_req(1'b1, 40'h600, 64'h77, 4'd2);
        tick();
        #1;
        check("mid_rst_rdy",  128'(bus.req_rdy_o), 128'(0));
        check("mid_rst_mval", 128'(bus.mem_req_val_o), 128'(0));
        check("mid_rst_addr", 128'(bus.mem_req_addr_o), 128'(0));
        check("mid_rst_wb",   128'(bus.wb_val_o), 128'(0));
        check("mid_rst_busy", 128'(bus.busy_o), 128'(0));
        check("mid_rst_err",  128'(bus.err_o), 128'(0));
        reset = 1'b1;
        idle_req();
        tick();
        drive_resp(1'b1, 2'd0, 64'h5);
        tick();
        drive_resp(1'b0, '0, '0);
        check("late_resp_err", 128'(bus.err_o), 128'(1));
        check("late_resp_no_wb", 128'(bus.wb_val_o), 128'(0));

        check("mreq_drained", 128'(exp_mreq.size()), 128'(0));
        check("wb_drained", 128'(exp_wb.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/asic_mem_port.md
Name: asic_mem_port

Overview:
- Memory-side stage directly downstream of the ASIC datapath's memory request outputs (R-file read ports 0/1 supply address/data).
- Registers requests and issues them to the processor memory interface with val/rdy and tags.
- Tracks outstanding transactions and returns load data, with the destination R-file index, on a val/rdy writeback port that feeds the datapath `r_wdata` bus through the response buffer.

Parameters:
- ADDR_BITS, 40, memory address width
- DATA_BITS, 64, memory data width
- TAG_BITS, 2, tag width; NTAGS = 2^TAG_BITS outstanding transactions max
- R_ADDR, 4, R-file index width carried with each load
- WB_DEPTH, 2, writeback FIFO entries (power of 2, >=1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- req_val_i  in  1  ctrl presents a request
- req_rdy_o  out  1  block accepts the request this cycle
- req_store_i  in  1  1=store, 0=load
- req_addr_i  in  ADDR_BITS  address (r_rdata0[39:0])
- req_data_i  in  DATA_BITS  store data (r_rdata1)
- req_rd_i  in  R_ADDR  R-file destination for a load
- mem_req_val_o  out  1  request valid to memory
- mem_req_rdy_i  in  1  memory accepts request
- mem_req_store_o  out  1  command type
- mem_req_addr_o  out  ADDR_BITS  address
- mem_req_data_o  out  DATA_BITS  store data
- mem_req_tag_o  out  TAG_BITS  transaction tag
- mem_resp_val_i  in  1  response valid (no backpressure)
- mem_resp_tag_i  in  TAG_BITS  response tag
- mem_resp_data_i  in  DATA_BITS  load data
- wb_val_o  out  1  writeback entry valid
- wb_rdy_i  in  1  ctrl consumes writeback (asserts resp_bus_en/r_wen)
- wb_data_o  out  DATA_BITS  load data to R-file
- wb_raddr_o  out  R_ADDR  R-file write index
- busy_o  out  1  any request held, outstanding, or in WB FIFO
- err_o  out  1  sticky: response with unallocated tag

Behaviour:
- Reset (reset==0 at posedge):
  - issue register empty; tag table all free; WB FIFO empty; err_o=0.
  - Outputs: mem_req_val_o=0, wb_val_o=0, busy_o=0, req_rdy_o=0 during reset.
  - Data/tag outputs are 0.
- Issue register (1 entry):
  - Acceptance: req_val_i&&req_rdy_o.
  - On accept, the lowest-index free tag is allocated, rd/store flag are written to tag table[tag], and the entry is loaded.
  - mem_req_val_o=1 from the next cycle until mem_req_rdy_i. Fields are stable while held.
- req_rdy_o = (issue reg empty OR mem fire this cycle) AND free tag exists AND (req_store_i OR load_credit>0).
  - Accept and issue in the same cycle are allowed (1 request/cycle throughput).
- load_credit = WB_DEPTH - (WB FIFO count + allocated load tags).
  - Guarantees every load response has FIFO space; responses are never dropped.
- Free-tag and credit computation uses registered state only. A tag freed by a response becomes allocatable the following cycle.
- Response handling:
  - mem_resp_val_i with allocated tag T:
    - Load: pushes {mem_resp_data_i, rd[T]} into the WB FIFO.
    - Store: no push.
    - In both cases T is freed.
  - mem_resp_val_i with unallocated tag: ignored, err_o<=1 (cleared only by reset).
- Responses may arrive in any tag order. The WB FIFO preserves response arrival order.
- WB FIFO:
  - wb_val_o = FIFO not empty, with head data/index.
  - Pop on wb_val_o&&wb_rdy_i.
  - Push and pop in the same cycle are allowed, including when full (credit rule prevents overflow) and when empty with a same-cycle push (entry is visible the next cycle).
- Latency:
  - req accept -> mem_req_val_o: 1 cycle.
  - mem_resp -> wb_val_o: 1 cycle.
  - Minimum load round trip, excluding memory: 2 cycles.
- busy_o = issue reg valid OR any tag allocated OR FIFO not empty (registered-state OR).
- Reset mid-operation: all state cleared. Late responses for pre-reset tags set err_o.

Test Plan:
- Single load: req addr=0x100, rd=5 accepted. Cycle+1: mem_req_val_o=1, tag=0, store=0. mem_resp tag=0, data=0xDEAD_BEEF two cycles later. Next cycle: wb_val_o=1, wb_data_o=0xDEADBEEF, wb_raddr_o=5; busy_o=0 after pop.
- Store: req_store_i=1, addr=0x40, data=0x1234 -> mem_req_data_o=0x1234. resp tag 0 -> no wb_val_o, tag freed, busy_o=0.
- Credit stall: WB_DEPTH=2, two loads (rd=1,2) issued, wb_rdy_i=0, third load -> req_rdy_o=0. After both responses and one pop, req_rdy_o=1 the cycle after the pop.
- Out-of-order: loads tags 0 (rd=3), 1 (rd=7); responses tag1 data=0xB then tag0 data=0xA -> wb sequence (0xB, 7) then (0xA, 3).
- Backpressure: mem_req_rdy_i=0 for 3 cycles -> mem_req_* held constant, req_rdy_o=0. On rdy=1, next pending req is accepted in the same cycle.
- Error/reset: mem_resp tag=2 with no allocation -> err_o=1 next cycle, stays set. reset=0 for 1 cycle mid-transaction -> all outputs zero, busy_o=0, err_o=0.
